load_store_unit: RTL and testbench

//  Memory-stage sequencer between execute and data_memory. Takes one load/store per handshake,

---
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer (IDLE -> REQ -> RESP) between execute and data_memory.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being issued.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [11:0]     i_imm,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic [XLEN-1:0] or_mem_data,
  output logic [2:0]      or_funct3,
  output logic            or_read_write,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            or_wb_valid,
  input  logic            i_wb_ready,
  output logic [XLEN-1:0] or_wb_data,
  output logic [4:0]      or_wb_rd,
  output logic            or_exc_valid,
  output logic [3:0]      or_exc_cause,
  output logic [XLEN-1:0] or_exc_tval
);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d, wb_data_q, wb_data_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic            store_q, store_d, exc_q, exc_d;
  logic [3:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ea;
  logic            legal, misaligned;
  assign ea = i_rs1 + {{(XLEN-12){i_imm[11]}}, i_imm};
  // loads accept 000/001/010/100/101, stores only 000/001/010
  assign legal = (i_funct3[1:0] != 2'b11) && (!i_funct3[2] || (!i_is_store && i_funct3[1:0] != 2'b10));
`ifdef MISALIGN_TRAP_EN
  assign misaligned = (i_funct3[1:0] == 2'b01 && ea[0]) || (i_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    exc_d     = exc_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: if (i_valid) begin
        addr_d    = ea;
        data_d    = i_rs2;
        funct3_d  = i_funct3;
        rd_d      = i_rd;
        store_d   = i_is_store;
        cnt_d     = '0;
        wb_data_d = '0;
        wb_rd_d   = '0;
        exc_d     = !legal || misaligned;
        cause_d   = !legal ? 4'd2 : misaligned ? (i_is_store ? 4'd6 : 4'd4) : 4'd0;
        state_d   = (!legal || misaligned) ? RESP : REQ;
      end
      REQ: begin
        if (i_mem_ack) begin
          state_d   = RESP;
          cnt_d     = '0;
          wb_data_d = store_q ? '0 : i_mem_data;
          wb_rd_d   = store_q ? 5'd0 : rd_q;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
          exc_d   = 1'b1;
          cause_d = store_q ? 4'd7 : 4'd5;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (i_wb_ready) begin
        state_d   = IDLE;
        exc_d     = 1'b0;
        cause_d   = 4'd0;
        wb_data_d = '0;
        wb_rd_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      store_q   <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      exc_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end
  assign o_ready       = state_q == IDLE;
  assign or_mem_req    = state_q == REQ;
  assign or_mem_addr   = addr_q;
  assign or_mem_data   = data_q;
  assign or_funct3     = funct3_q;
  assign or_read_write = (state_q == REQ) && !store_q;
  assign or_wb_valid   = state_q == RESP;
  assign or_wb_data    = wb_data_q;
  assign or_wb_rd      = wb_rd_q;
  assign or_exc_valid  = (state_q == RESP) && exc_q;
  assign or_exc_cause  = cause_q;
  assign or_exc_tval   = exc_q ? addr_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench; the bench also plays data_memory over a byte array.
module tb_load_store_unit;
  localparam int T = 16;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 0, rst = 1, valid = 0, is_store = 0, mem_ack = 0, wb_ready = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0, mem_data = 0;
  logic [11:0] imm = 0;
  logic [4:0]  rd = 0;
  logic        ready, mem_req, read_write, wb_valid, exc_valid;
  logic [31:0] mem_addr, mem_wdata, wb_data, exc_tval;
  logic [2:0]  mem_f3;
  logic [4:0]  wb_rd;
  logic [3:0]  exc_cause;
  int checks = 0, errors = 0;
  logic [7:0] mem [0:1023];

  load_store_unit #(.XLEN(32), .ACK_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_is_store(is_store),
    .i_funct3(funct3), .i_rs1(rs1), .i_imm(imm), .i_rs2(rs2), .i_rd(rd),
    .or_mem_req(mem_req), .or_mem_addr(mem_addr), .or_mem_data(mem_wdata), .or_funct3(mem_f3),
    .or_read_write(read_write), .i_mem_ack(mem_ack), .i_mem_data(mem_data),
    .or_wb_valid(wb_valid), .i_wb_ready(wb_ready), .or_wb_data(wb_data), .or_wb_rd(wb_rd),
    .or_exc_valid(exc_valid), .or_exc_cause(exc_cause), .or_exc_tval(exc_tval));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem[10'(a + 3)], mem[10'(a + 2)], mem[10'(a + 1)], mem[a[9:0]]};
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic write_mem(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n;
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    for (int k = 0; k < n; k++) mem[10'(a + k)] = d[8*k +: 8];
  endtask

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] b, input logic [11:0] off,
                        input logic [31:0] sd, input logic [4:0] dst, input int dly, input int stall);
    logic [31:0] a, exp_data;
    logic [3:0]  cause;
    bit          legal, mis, tmo, fault;
    int          n;
    a        = b + {{20{off[11]}}, off};
    legal    = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis      = TRAP && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0));
    tmo      = legal && !mis && dly >= T;
    fault    = !legal || mis || tmo;
    cause    = !legal ? 4'd2 : mis ? (st ? 4'd6 : 4'd4) : tmo ? (st ? 4'd7 : 4'd5) : 4'd0;
    exp_data = (fault || st) ? 32'd0 : load_val(a, f3);
    chk("ready", {31'd0, ready}, 32'd1);
    is_store = st; funct3 = f3; rs1 = b; imm = off; rs2 = sd; rd = dst; valid = 1;
    @(negedge clk);
    valid = 0;
    if (!legal || mis) chk("no_req", {31'd0, mem_req}, 32'd0);
    else begin
      chk("addr", mem_addr, a);
      chk("f3", {29'd0, mem_f3}, {29'd0, f3});
      chk("rw", {31'd0, read_write}, {31'd0, !st});
      if (st) chk("sdata", mem_wdata, sd);
      n = 0;
      for (int k = 0; k < (tmo ? T : dly); k++) begin
        if (mem_req === 1'b1) n++;
        @(negedge clk);
      end
      chk("req_cycles", n, tmo ? T : dly);
      if (tmo) chk("req_drop", {31'd0, mem_req}, 32'd0);
      else begin
        chk("req_ack", {31'd0, mem_req}, 32'd1);
        mem_ack = 1;
        if (st) write_mem(mem_addr, mem_wdata, mem_f3);
        else mem_data = load_val(mem_addr, mem_f3);
        @(negedge clk);
        mem_ack = 0;
        mem_data = $urandom;
      end
    end
    for (int k = 0; k < stall; k++) begin
      chk("wb_hold", {31'd0, wb_valid}, 32'd1);
      @(negedge clk);
    end
    wb_ready = 1;
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("exc_valid", {31'd0, exc_valid}, {31'd0, fault});
    if (fault) begin
      chk("cause", {28'd0, exc_cause}, {28'd0, cause});
      chk("tval", exc_tval, a);
    end
    chk("wb_data", wb_data, exp_data);
    chk("wb_rd", {27'd0, wb_rd}, (fault || st) ? 32'd0 : {27'd0, dst});
    @(negedge clk);
    wb_ready = 0;
    chk("wb_drop", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] w;
    int          dly;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc", {31'd0, exc_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    rst = 0;
    @(negedge clk);
    w = 32'hDEADBEEF;
    write_mem(32'h104, w, 3'd2);
    access(0, 3'd2, 32'h100, 12'd4, 0, 5'd7, 0, 0);
    access(1, 3'd0, 32'h103, 12'd0, 32'h123456AB, 5'd3, 1, 0);
    access(0, 3'd4, 32'h103, 12'd0, 0, 5'd9, 0, 0);
    chk("sb_readback", {24'd0, mem[10'h103]}, 32'h000000AB);
    mem[10'h1FF] = 8'h80;
    access(0, 3'd0, 32'h200, 12'hFFF, 0, 5'd4, 2, 1);
    access(0, 3'd2, 32'h40, 12'd0, 0, 5'd5, T, 0);
    access(1, 3'd2, 32'h80, 12'd0, 32'hCAFEF00D, 5'd0, T, 2);
    access(0, 3'd2, 32'h84, 12'd0, 0, 5'd6, T - 1, 0);
    access(0, 3'd1, 32'h101, 12'd0, 0, 5'd8, 0, 0);
    access(1, 3'd2, 32'h102, 12'd0, 32'h0BADCAFE, 5'd0, 0, 0);
    access(0, 3'd3, 32'h10, 12'd0, 0, 5'd2, 0, 3);
    access(1, 3'd4, 32'h10, 12'd0, 0, 5'd2, 0, 0);
    access(0, 3'd2, 32'hFFFFFFFE, 12'd2, 0, 5'd1, 0, 0);
    is_store = 0; funct3 = 3'd2; rs1 = 32'h20; imm = 0; valid = 1;
    @(negedge clk);
    valid = 0;
    repeat (2) @(negedge clk);
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    chk("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
    for (int i = 0; i < 150; i++) begin
      st = ($urandom % 3) == 0;
      if ($urandom % 6 == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      dly = ($urandom % 12 == 0) ? T : ($urandom % 12 == 0) ? T - 1 : $urandom_range(0, 3);
      access(st, f3, $urandom_range(0, 2047), 12'($urandom), $urandom, 5'($urandom), dly, $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
